aes_resp_misr: RTL
==================

Name: aes_resp_misr

Overview:
- Response-side companion to the LFSR stimulus generators that feed aes_128.
- Compacts the aes_128 ciphertext stream into a 128-bit multiple-input signature register (MISR) over a programmed number of encryptions, then compares the result with an expected golden signature.
- Synthesizable; sits alongside aes_128 so that long randomized runs yield one pass/fail bit instead of a full output dump.

Parameters:
- DATA_W, 128, width of aes_out, signature and expected_sig.
- LATENCY, 21, cycles from the first stimulus edge to the first valid aes_out; legal range 1 to 255.
- MISR_SEED, 128'h0, signature value loaded on start.
- MISR_POLY, 128'h87, feedback taps (x^128+x^7+x^2+x+1), applied when the signature MSB shifts out.

Ports:
- clk  input  1  rising-edge clock, same clock as aes_128.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; sampled only in IDLE or DONE.
- num_tests  input  32  number of ciphertexts to compact; sampled on the start edge.
- aes_out  input  DATA_W  aes_128 out bus.
- expected_sig  input  DATA_W  golden signature; sampled on the compare edge.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next accepted start or reset.
- pass  output  1  signature == expected_sig; valid only while done=1.
- signature  output  DATA_W  current MISR contents.
- sample_count  output  32  ciphertexts compacted so far in this run.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, pass=0, signature=MISR_SEED, sample_count=0, internal counters=0.
  - Applies immediately, including mid-run; the run is abandoned and no done is produced.
- States: IDLE, WARMUP, CAPTURE, COMPARE, DONE.
- IDLE/DONE, start=1 at edge E0:
  - Load signature=MISR_SEED, sample_count=0, latch num_tests.
  - Clear done and pass; set busy=1.
  - If num_tests==0, go to COMPARE. If LATENCY==1, go to CAPTURE. Otherwise go to WARMUP with the warm-up counter set to LATENCY-1.
- Stimulus alignment: E0 is the first edge at which aes_128 sees the first stimulus. Ciphertext k (k=0..N-1) is valid at edge E0+LATENCY+k.
- WARMUP:
  - aes_out is ignored.
  - Counter decrements each edge; enter CAPTURE so that the first sample is taken at edge E0+LATENCY.
- CAPTURE: one sample per edge.
  - Update: signature <= {signature[DATA_W-2:0],1'b0} ^ (signature[DATA_W-1] ? MISR_POLY : 0) ^ aes_out.
  - sample_count increments by 1.
  - When sample_count reaches N-1 at the edge (the last sample), the next state is COMPARE.
- COMPARE: lasts one cycle.
  - pass <= (signature == expected_sig), done <= 1, busy <= 0; next state is DONE.
  - done rises at edge E0+LATENCY+N for N>0, and at E0+1 for N=0.
- DONE: holds signature, sample_count, pass and done stable until start or reset.
- start while busy is ignored and has no side effects.
- sample_count saturates only by construction: it never exceeds N.
- No bubbles: aes_128 is fully pipelined, so every CAPTURE edge is a sample.

Test Plan:
- Reset values: rst_n=0 for 3 cycles, then release -> busy=0, done=0, pass=0, signature=0, sample_count=0.
- Single sample: num_tests=1, aes_out=128'h1 only at edge E0+21, 0 otherwise, expected_sig=128'h1 -> signature=128'h1; done=1 and pass=1 from edge E0+22; busy high for edges E0..E0+21.
- Warm-up exclusion and feedback: aes_out=128'hFFFF at edge E0+20 only, then 128'h1 at E0+21, 128'h0 at E0+22, num_tests=2 -> signature=128'h2, sample_count=2, done at E0+23. Separately, MISR_SEED=128'h8000_0000_0000_0000_0000_0000_0000_0000, num_tests=1, aes_out=0 -> signature=128'h87.
- Zero tests and mismatch: num_tests=0, expected_sig=128'h5 -> done at E0+1, signature=seed=0, pass=0, sample_count=0.
- Start while busy and restart: pulse start at E0+5 mid-run -> run completes unchanged. Then start from DONE with num_tests=1 -> done and pass cleared at the start edge, new result produced 22 edges later.
- Reset mid-operation: rst_n low at E0+23 of a num_tests=10 run -> all outputs return to reset values immediately; no done pulse follows after release.

Source files
------------

// File: rtl/aes_resp_misr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : aes_resp_misr                                            |
// | Description : Compacts the aes_128 ciphertext stream into a 128-bit    |
// |               MISR over a programmed number of encryptions, then       |
// |               compares the signature with a golden value.              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module aes_resp_misr #(
    parameter int                 DATA_W    = 128,
    parameter int                 LATENCY   = 21,
    parameter logic [DATA_W-1:0]  MISR_SEED = '0,
    parameter logic [DATA_W-1:0]  MISR_POLY = 128'h87
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       num_tests,
    input  logic [DATA_W-1:0] aes_out,
    input  logic [DATA_W-1:0] expected_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] signature,
    output logic [31:0]       sample_count
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_warmup  = 3'd1;
    localparam logic [2:0] c_st_capture = 3'd2;
    localparam logic [2:0] c_st_compare = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    // Warm-up starts at LATENCY-1 so the first CAPTURE edge is E0+LATENCY.
    localparam logic [7:0] c_warm_init  = 8'(LATENCY - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [7:0]        r_warm_cnt;
    logic [31:0]       r_num_tests;
    logic [DATA_W-1:0] r_sig;
    logic [31:0]       r_count;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic              w_idle_like;
    logic              w_last;
    logic [DATA_W-1:0] w_misr_next;

    // A start is only honoured when no run is in flight.
    assign w_idle_like = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_last      = (r_count == (r_num_tests - 32'd1));
    assign w_misr_next = {r_sig[DATA_W-2:0], 1'b0}
                       ^ (r_sig[DATA_W-1] ? MISR_POLY : '0)
                       ^ aes_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: warm-up skipped for LATENCY==1, capture skipped for N==0.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    if (num_tests == 32'd0) begin
                        w_next_state = c_st_compare;
                    end else if (LATENCY == 1) begin
                        w_next_state = c_st_capture;
                    end else begin
                        w_next_state = c_st_warmup;
                    end
                end
            end
            c_st_warmup: begin
                if (r_warm_cnt == 8'd1) begin
                    w_next_state = c_st_capture;
                end
            end
            c_st_capture: begin
                if (w_last) begin
                    w_next_state = c_st_compare;
                end
            end
            c_st_compare: begin
                w_next_state = c_st_done;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Datapath: run setup, warm-up countdown, MISR compaction and final compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt  <= '0;
            r_num_tests <= '0;
            r_sig       <= MISR_SEED;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_sig       <= MISR_SEED;
                        r_count     <= '0;
                        r_num_tests <= num_tests;
                        r_warm_cnt  <= c_warm_init;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                c_st_warmup: begin
                    r_warm_cnt <= r_warm_cnt - 8'd1;
                end
                c_st_capture: begin
                    r_sig   <= w_misr_next;
                    r_count <= r_count + 32'd1;
                end
                c_st_compare: begin
                    r_pass <= (r_sig == expected_sig);
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign signature    = r_sig;
    assign sample_count = r_count;

endmodule
`default_nettype wire
